// File: rtl/fft_frame_packer_if.sv
// rtl/fft_frame_packer_if.sv - sample input and FFT-side output bundle for fft_frame_packer
interface fft_frame_packer_if #(
   parameter int SW = 16
);
   logic                 en;
   logic                 sample_valid;
   logic signed [SW-1:0] sample_in;
   logic                 next;
   logic [63:0]          i0;
   logic [63:0]          i1;
   logic                 busy;
   logic                 overrun;

   modport master (
      output en, sample_valid, sample_in,
      input  next, i0, i1, busy, overrun
   );

   modport slave (
      input  en, sample_valid, sample_in,
      output next, i0, i1, busy, overrun
   );
endinterface

// File: rtl/fft_frame_packer.sv
// rtl/fft_frame_packer.sv - ping-pong sample banks streamed as complex pairs to an FFT
module fft_frame_packer #(
   parameter int SW   = 16,
   parameter int N    = 32,
   parameter int LEAD = 6
) (
   input  logic              clk,
   input  logic              rst,
   fft_frame_packer_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int KW = $clog2(N / 2 + 1);
   localparam int CW = $clog2(LEAD) + 1;

   typedef enum logic [1:0] {IDLE, LEADIN, STREAM} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] k_q, k_d;
   logic          rbank_q, rbank_d;
   logic          wbank_q, wbank_d;
   logic [IW-1:0] widx_q, widx_d;
   logic [1:0]    pend_q, pend_d;
   logic          next_q, next_d;
   logic [63:0]   i0_q, i0_d;
   logic [63:0]   i1_q, i1_d;
   logic          busy_q, busy_d;
   logic          overrun_q, overrun_d;
   logic [SW-1:0] mem_q [2][N];

   logic          take, take_bank, free_now, load;
   logic [IW-2:0] pk;
   logic          we, wb, full, other_free;
   logic [IW-1:0] wi;

   function automatic logic [63:0] pack(input logic [SW-1:0] s);
      return {32'd0, {(32 - SW){s[SW-1]}}, s};
   endfunction

   // Read side: a pending bank is either the swapped-out bank or a full write bank stalled at the wrap.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      rbank_d   = rbank_q;
      next_d    = 1'b0;
      i0_d      = '0;
      i1_d      = '0;
      take      = 1'b0;
      take_bank = ~wbank_q;
      free_now  = 1'b0;
      load      = 1'b0;
      pk        = '0;
      unique case (state_q)
         IDLE: begin
            if (pend_q[~wbank_q]) begin
               take      = 1'b1;
               take_bank = ~wbank_q;
            end else if (pend_q[wbank_q]) begin
               take      = 1'b1;
               take_bank = wbank_q;
            end
         end
         LEADIN: begin
            if (cnt_q == CW'(LEAD - 1)) begin
               state_d = STREAM;
               load    = 1'b1;
               k_d     = KW'(1);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STREAM: begin
            if (k_q == KW'(N / 2)) begin
               free_now = 1'b1;
               if (pend_q[~rbank_q]) begin
                  take      = 1'b1;
                  take_bank = ~rbank_q;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               load = 1'b1;
               pk   = k_q[IW-2:0];
               k_d  = k_q + KW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         i0_d = pack(mem_q[rbank_q][{pk, 1'b0}]);
         i1_d = pack(mem_q[rbank_q][{pk, 1'b1}]);
      end
      if (take) begin
         state_d = LEADIN;
         next_d  = 1'b1;
         cnt_d   = '0;
         rbank_d = take_bank;
      end
      busy_d = (state_d != IDLE);
   end

   // Write side: taking the stalled write bank hands the freed bank back to the writer.
   always_comb begin
      wb         = wbank_q;
      wi         = widx_q;
      full       = pend_q[wbank_q];
      pend_d     = pend_q;
      overrun_d  = overrun_q;
      we         = 1'b0;
      if (take) begin
         pend_d[take_bank] = 1'b0;
      end
      if (take && take_bank == wbank_q) begin
         wb   = ~wbank_q;
         wi   = '0;
         full = 1'b0;
      end
      wbank_d    = wb;
      widx_d     = wi;
      other_free = !pend_q[~wb] && (state_q == IDLE || rbank_q != ~wb || free_now);
      if (!bus.en) begin
         if (!full) begin
            widx_d = '0;
         end
      end else if (bus.sample_valid) begin
         if (full) begin
            overrun_d = 1'b1;
         end else begin
            we = 1'b1;
            if (wi == IW'(N - 1)) begin
               pend_d[wb] = 1'b1;
               if (other_free) begin
                  wbank_d = ~wb;
                  widx_d  = '0;
               end
            end else begin
               widx_d = wi + IW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         k_q       <= '0;
         rbank_q   <= 1'b0;
         wbank_q   <= 1'b0;
         widx_q    <= '0;
         pend_q    <= '0;
         next_q    <= 1'b0;
         i0_q      <= '0;
         i1_q      <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         rbank_q   <= rbank_d;
         wbank_q   <= wbank_d;
         widx_q    <= widx_d;
         pend_q    <= pend_d;
         next_q    <= next_d;
         i0_q      <= i0_d;
         i1_q      <= i1_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wb][wi] <= bus.sample_in;
      end
   end

   assign bus.next    = next_q;
   assign bus.i0      = i0_q;
   assign bus.i1      = i1_q;
   assign bus.busy    = busy_q;
   assign bus.overrun = overrun_q;
endmodule
